mac_seq_28: RTL and testbench

MAC_SEQ_28 -- requirements
Module: mac_seq_28

---
 rtl/mac_seq_28.sv | 189 ++++++++++++++++++
 tb/tb_mac_seq_28.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_28.sv
// ---------------------------------------------------------------------------
// mac_seq_28 -- sequencer for an external LANES-wide int8 MAC array.
//
// Accepts a stream of operand beats (one int8 A and B per lane per beat),
// clears the array accumulators, feeds every accepted beat onto A_bus/B_bus
// for exactly one cycle, waits for the array pipeline to drain, pulses
// rescale so the array quantizes its accumulators, captures the low byte of
// each quantized lane and presents the packed result on a valid/ready port.
//
// Parameters:
//   LANES    number of MAC lanes (default 28)
//   MAC_LAT  array latency from operand bus to PQ result (default 2)
//
// Ports:
//   clk                 rising-edge clock
//   main_rst            asynchronous active-low reset
//   s_valid/s_ready     operand beat handshake
//   s_a, s_b            packed signed int8 operands, lane i at [8i+7:8i]
//   s_last              final beat of a dot-product
//   A_bus, B_bus        registered operands to the array (zero on bubbles)
//   mac_rst             accumulator clear to the array
//   rescale             quantization enable to the array
//   pq_bus              quantized lane results, 32 bits per lane
//   m_valid/m_ready     result vector handshake
//   m_data              packed int8 results, lane i at [8i+7:8i]
//
// Optional build macro MAC_SEQ_STATUS_EN adds:
//   beat_cnt            beats accepted in the current/last dot-product,
//                       saturating at 16'hFFFF
//   ovf                 set when a 65536th beat is accepted
// ---------------------------------------------------------------------------
module mac_seq_28 #(
  parameter int LANES   = 28,
  parameter int MAC_LAT = 2
) (
  input  logic                clk,
  input  logic                main_rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [LANES*8-1:0]  s_a,
  input  logic [LANES*8-1:0]  s_b,
  input  logic                s_last,
  output logic [LANES*8-1:0]  A_bus,
  output logic [LANES*8-1:0]  B_bus,
  output logic                mac_rst,
  output logic                rescale,
  input  logic [LANES*32-1:0] pq_bus,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [LANES*8-1:0]  m_data
`ifdef MAC_SEQ_STATUS_EN
  ,
  output logic [15:0]         beat_cnt,
  output logic                ovf
`endif
);

  localparam int DW = $clog2(MAC_LAT + 2);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(MAC_LAT);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DRAIN,
    RESCALE,
    OUT
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [DW-1:0]      r_drainCnt;
  logic               r_inReset;
  logic [LANES*8-1:0] r_aBus;
  logic [LANES*8-1:0] r_bBus;
  logic [LANES*8-1:0] r_mData;
  logic               w_accept;
  logic               w_unused;

  // The array's lanes are already clamped to int8, so only the low byte of
  // each 32-bit lane carries information; the sign-extension bits are
  // deliberately not consumed.
  assign w_unused = ^pq_bus;

  assign w_accept = s_ready & s_valid;
  assign A_bus    = r_aBus;
  assign B_bus    = r_bBus;
  assign m_data   = r_mData;

  // State register.
  always_ff @(posedge clk or negedge main_rst) begin
    if (!main_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake/control outputs. mac_rst is also held high by
  // r_inReset so the array stays cleared while the sequencer is in reset and
  // is released on the first edge after reset deasserts.
  always_comb begin
    w_nextState = r_state;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    mac_rst     = r_inReset;
    rescale     = 1'b0;
    case (r_state)
      IDLE: begin
        if (s_valid) w_nextState = CLEAR;
      end
      CLEAR: begin
        mac_rst     = 1'b1;
        w_nextState = ACCUM;
      end
      ACCUM: begin
        s_ready = 1'b1;
        if (s_valid && s_last) w_nextState = DRAIN;
      end
      DRAIN: begin
        if (r_drainCnt == DRAIN_LAST) w_nextState = RESCALE;
      end
      RESCALE: begin
        rescale     = 1'b1;
        w_nextState = OUT;
      end
      OUT: begin
        m_valid = 1'b1;
        if (m_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: operand buses carry an accepted beat for exactly one cycle and
  // zero otherwise, the drain counter spans MAC_LAT+1 cycles so the last beat
  // has settled in the accumulators before rescale, and the result is
  // captured from the array at the end of the rescale cycle.
  always_ff @(posedge clk or negedge main_rst) begin
    if (!main_rst) begin
      r_inReset  <= 1'b1;
      r_aBus     <= '0;
      r_bBus     <= '0;
      r_drainCnt <= '0;
      r_mData    <= '0;
    end else begin
      r_inReset <= 1'b0;
      r_aBus    <= w_accept ? s_a : '0;
      r_bBus    <= w_accept ? s_b : '0;
      if (r_state == DRAIN) begin
        r_drainCnt <= r_drainCnt + 1'b1;
      end else begin
        r_drainCnt <= '0;
      end
      if (r_state == RESCALE) begin
        for (int i = 0; i < LANES; i++) begin
          r_mData[8*i +: 8] <= pq_bus[32*i +: 8];
        end
      end
    end
  end

`ifdef MAC_SEQ_STATUS_EN
  logic [15:0] r_beatCnt;
  logic        r_ovf;

  // Beat statistics for the current dot-product; the count sticks at its
  // maximum and the beat that would wrap it raises ovf instead.
  always_ff @(posedge clk or negedge main_rst) begin
    if (!main_rst) begin
      r_beatCnt <= '0;
      r_ovf     <= 1'b0;
    end else if (r_state == CLEAR) begin
      r_beatCnt <= '0;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      if (r_beatCnt == 16'hFFFF) begin
        r_ovf <= 1'b1;
      end else begin
        r_beatCnt <= r_beatCnt + 16'd1;
      end
    end
  end

  assign beat_cnt = r_beatCnt;
  assign ovf      = r_ovf;
`endif

endmodule

// File: tb/tb_mac_seq_28.sv
// ---------------------------------------------------------------------------
// tb_mac_seq_28 -- self-checking bench for mac_seq_28.
//
// Contains a simple model of the external MAC array (MAC_LAT-deep product
// pipeline, accumulators, quantization with M=256, S_shift=8, Z=0) that
// drives pq_bus, a transaction-level scoreboard that predicts each result
// vector from the accepted beats, and a per-cycle compare process.
// Define MAC_SEQ_STATUS_EN to also exercise beat_cnt/ovf.
// ---------------------------------------------------------------------------
module tb_mac_seq_28;

  localparam int LANES   = 28;
  localparam int MAC_LAT = 2;
  localparam int MODE_CONST = 0;
  localparam int MODE_FULL  = 1;
  localparam int MODE_SMALL = 2;

  logic                clk = 1'b0;
  logic                main_rst = 1'b1;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic [LANES*8-1:0]  s_a = '0;
  logic [LANES*8-1:0]  s_b = '0;
  logic                s_last = 1'b0;
  logic [LANES*8-1:0]  A_bus;
  logic [LANES*8-1:0]  B_bus;
  logic                mac_rst;
  logic                rescale;
  logic [LANES*32-1:0] pq_bus;
  logic                m_valid;
  logic                m_ready = 1'b0;
  logic [LANES*8-1:0]  m_data;
`ifdef MAC_SEQ_STATUS_EN
  logic [15:0]         beat_cnt;
  logic                ovf;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mac_seq_28 #(.LANES(LANES), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk),
    .main_rst(main_rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_a(s_a),
    .s_b(s_b),
    .s_last(s_last),
    .A_bus(A_bus),
    .B_bus(B_bus),
    .mac_rst(mac_rst),
    .rescale(rescale),
    .pq_bus(pq_bus),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data)
`ifdef MAC_SEQ_STATUS_EN
    ,
    .beat_cnt(beat_cnt),
    .ovf(ovf)
`endif
  );

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int clamp8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // MAC array stand-in: products enter a MAC_LAT-deep pipe, then accumulate.
  int prodPipe [MAC_LAT][LANES];
  int acc [LANES];

  always @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (mac_rst) begin
        acc[l] <= 0;
        for (int s = 0; s < MAC_LAT; s++) prodPipe[s][l] <= 0;
      end else begin
        acc[l] <= acc[l] + prodPipe[MAC_LAT-1][l];
        for (int s = MAC_LAT - 1; s > 0; s--) prodPipe[s][l] <= prodPipe[s-1][l];
        prodPipe[0][l] <= int'($signed(A_bus[8*l +: 8])) * int'($signed(B_bus[8*l +: 8]));
      end
    end
  end

  // Quantized output only while rescale is high; a filler pattern otherwise
  // so a capture at the wrong moment is visible.
  always_comb begin
    pq_bus = '0;
    for (int l = 0; l < LANES; l++) begin
      pq_bus[32*l +: 32] = rescale ? 32'(clamp8((acc[l] * 256) >>> 8)) : 32'h5A5A_5A5A;
    end
  end

  // Scoreboard and per-cycle compare, sampled on the falling edge.
  int                 sumLane [LANES];
  logic [LANES*8-1:0] expQ [$];
  logic               pendAcc = 1'b0;
  logic [LANES*8-1:0] pendA = '0;
  logic [LANES*8-1:0] pendB = '0;
  int                 macRun = 0;
  int                 rescaleRun = 0;
  logic               prevSready = 1'b0;
  logic               prevMvalid = 1'b0;

  always @(negedge clk) begin
    logic [LANES*8-1:0] e;
    int v;
    if (!main_rst) begin
      pendAcc = 1'b0;
      for (int l = 0; l < LANES; l++) sumLane[l] = 0;
      expQ.delete();
      macRun = 0;
      rescaleRun = 0;
      prevSready = 1'b0;
      prevMvalid = 1'b0;
    end else begin
      checkOutput("A_bus", A_bus, pendAcc ? pendA : '0);
      checkOutput("B_bus", B_bus, pendAcc ? pendB : '0);
      checkOutput("ready_valid_excl", s_ready & m_valid, 0);
      if (s_ready && !prevSready) begin
        checkOutput("clear_pulse_len", macRun, 1);
        checkOutput("mac_rst_in_accum", mac_rst, 0);
      end
      if (m_valid && !prevMvalid) begin
        checkOutput("rescale_pulse_len", rescaleRun, 1);
        checkOutput("rescale_in_out", rescale, 0);
      end
      if (m_valid) begin
        checkOutput("result_pending", expQ.size() > 0, 1);
        if (expQ.size() > 0) begin
          checkOutput("m_data", m_data, expQ[0]);
          if (m_ready) void'(expQ.pop_front());
        end
      end
      pendAcc = s_valid && s_ready;
      pendA = s_a;
      pendB = s_b;
      if (pendAcc) begin
        for (int l = 0; l < LANES; l++) begin
          sumLane[l] += int'($signed(s_a[8*l +: 8])) * int'($signed(s_b[8*l +: 8]));
        end
        if (s_last) begin
          for (int l = 0; l < LANES; l++) begin
            v = clamp8(sumLane[l]);
            e[8*l +: 8] = v[7:0];
            sumLane[l] = 0;
          end
          expQ.push_back(e);
        end
      end
      macRun = mac_rst ? macRun + 1 : 0;
      rescaleRun = rescale ? rescaleRun + 1 : 0;
      prevSready = s_ready;
      prevMvalid = m_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat after a gap of idle cycles and hold it until accepted.
  task automatic sendBeat(input logic [LANES*8-1:0] a, input logic [LANES*8-1:0] b,
                          input logic last, input int gap);
    logic accepted;
    accepted = 1'b0;
    s_valid = 1'b0;
    repeat (gap) tick();
    s_valid = 1'b1;
    s_a = a;
    s_b = b;
    s_last = last;
    for (int c = 0; c < 200 && !accepted; c++) begin
      @(negedge clk);
      accepted = s_ready;
      tick();
    end
    checkOutput("beat_accepted", accepted, 1);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic applyStimulus(input int k, input int gap, input int mode,
                               input logic [7:0] ca, input logic [7:0] cb);
    logic [LANES*8-1:0] a;
    logic [LANES*8-1:0] b;
    int g;
    for (int i = 0; i < k; i++) begin
      for (int l = 0; l < LANES; l++) begin
        if (mode == MODE_CONST) begin
          a[8*l +: 8] = ca;
          b[8*l +: 8] = cb;
        end else if (mode == MODE_FULL) begin
          a[8*l +: 8] = 8'($urandom);
          b[8*l +: 8] = 8'($urandom);
        end else begin
          a[8*l +: 8] = 8'($urandom_range(0, 15)) - 8'd8;
          b[8*l +: 8] = 8'($urandom_range(0, 15)) - 8'd8;
        end
      end
      g = (i == 0) ? 0 : ((gap < 0) ? int'($urandom_range(0, 3)) : gap);
      sendBeat(a, b, i == k - 1, g);
    end
  endtask

  // Wait for the result, hold m_ready low for 'delay' OUT cycles, accept it.
  task automatic collectResult(input int delay, output logic [LANES*8-1:0] res);
    int c;
    c = 0;
    m_ready = (delay == 0);
    @(negedge clk);
    while (!m_valid && c < 300) begin
      @(negedge clk);
      c++;
    end
    checkOutput("m_valid_seen", m_valid, 1);
    res = m_data;
    for (int d = 0; d < delay; d++) begin
      tick();
      checkOutput("m_valid_hold", m_valid, 1);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checkOutput("idle_after_out", {m_valid, s_ready}, 2'b00);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [LANES*8-1:0] res;
    logic [LANES*8-1:0] a1;
    logic [LANES*8-1:0] b1;

    // Asynchronous reset, checked before any clock edge.
    #1 main_rst = 1'b0;
    #2;
    checkOutput("rst_s_ready", s_ready, 0);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_mac_rst", mac_rst, 1);
    checkOutput("rst_rescale", rescale, 0);
    checkOutput("rst_A_bus", A_bus, '0);
    checkOutput("rst_B_bus", B_bus, '0);
    checkOutput("rst_m_data", m_data, '0);
    repeat (3) tick();
    main_rst = 1'b1;
    tick();
    checkOutput("mac_rst_released", mac_rst, 0);
    checkOutput("idle_s_ready", s_ready, 0);
    tick();

    // Three beats of 2*3 on every lane.
    applyStimulus(3, 0, MODE_CONST, 8'd2, 8'd3);
    collectResult(0, res);
    checkOutput("three_beats_18", res, {LANES{8'd18}});

    // Four beats of -4*5 with two idle cycles between beats, then gap-free.
    applyStimulus(4, 2, MODE_CONST, 8'hFC, 8'd5);
    collectResult(3, res);
    checkOutput("gapped_minus80", res, {LANES{8'hB0}});
    applyStimulus(4, 0, MODE_CONST, 8'hFC, 8'd5);
    collectResult(0, res);
    checkOutput("gapfree_minus80", res, {LANES{8'hB0}});

    // Long backpressure in OUT.
    applyStimulus(2, 0, MODE_SMALL, 8'd0, 8'd0);
    collectResult(10, res);

    // Reset in the middle of accumulation after two beats.
    for (int l = 0; l < LANES; l++) begin
      a1[8*l +: 8] = 8'($urandom);
      b1[8*l +: 8] = 8'($urandom);
    end
    sendBeat(a1, b1, 1'b0, 0);
    sendBeat(b1, a1, 1'b0, 1);
    #2 main_rst = 1'b0;
    #1;
    checkOutput("midrst_s_ready", s_ready, 0);
    checkOutput("midrst_m_valid", m_valid, 0);
    checkOutput("midrst_mac_rst", mac_rst, 1);
    checkOutput("midrst_rescale", rescale, 0);
    checkOutput("midrst_A_bus", A_bus, '0);
    checkOutput("midrst_B_bus", B_bus, '0);
    checkOutput("midrst_m_data", m_data, '0);
    repeat (2) tick();
    main_rst = 1'b1;
    tick();
    checkOutput("midrst_mac_rst_released", mac_rst, 0);
    applyStimulus(1, 0, MODE_CONST, 8'd1, 8'd1);
    collectResult(1, res);
    checkOutput("after_rst_one", res, {LANES{8'd1}});

`ifdef MAC_SEQ_STATUS_EN
    applyStimulus(5, -1, MODE_SMALL, 8'd0, 8'd0);
    collectResult(0, res);
    checkOutput("beat_cnt_5", beat_cnt, 16'd5);
    checkOutput("ovf_5", ovf, 0);
    applyStimulus(1, 0, MODE_SMALL, 8'd0, 8'd0);
    collectResult(0, res);
    checkOutput("beat_cnt_1", beat_cnt, 16'd1);
    checkOutput("ovf_1", ovf, 0);
`endif

    // Randomized dot-products of varying length, gaps and backpressure.
    for (int t = 0; t < 25; t++) begin
      applyStimulus(int'($urandom_range(1, 6)), -1,
                    (t % 2 == 0) ? MODE_SMALL : MODE_FULL, 8'd0, 8'd0);
      collectResult(int'($urandom_range(0, 4)), res);
    end

    repeat (3) tick();
    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
